// File: rtl/voxel_shader_if.sv
// Hit-in / screen-buffer-out bundle for the voxel shading stage.
// master drives hits and frame control; slave is the shader.
interface voxel_shader_if #(
   parameter int PIXELS = 76800
);
   localparam int AW = $clog2(PIXELS);

   logic          frame_start;
   logic          hit_valid;
   logic [2:0]    hit;
   logic [5:0]    hit_norm;   // {x,y,z}, each a 2-bit two's-complement value in {-1,0,+1}
   logic [AW-1:0] pixel_addr;
   logic [15:0]   sbuf_data;
   logic [AW-1:0] sbuf_addr;
   logic          sbuf_write_enable;
   logic [AW:0]   pixel_count;
   logic          frame_shaded;

   modport master (
      output frame_start, hit_valid, hit, hit_norm, pixel_addr,
      input  sbuf_data, sbuf_addr, sbuf_write_enable, pixel_count, frame_shaded
   );

   modport slave (
      input  frame_start, hit_valid, hit, hit_norm, pixel_addr,
      output sbuf_data, sbuf_addr, sbuf_write_enable, pixel_count, frame_shaded
   );
endinterface

// File: rtl/voxel_shader.sv
// Three-stage voxel hit shader: base colour lookup, face brightness scaling,
// RGB565 screen-buffer write with per-frame pixel counting.
module voxel_shader #(
   parameter int PIXELS       = 76800,
   parameter int SHADE_TOP    = 256,
   parameter int SHADE_BOTTOM = 128,
   parameter int SHADE_X      = 205,
   parameter int SHADE_Z      = 154
) (
   input logic           clk_in,
   input logic           rst_in,
   voxel_shader_if.slave bus
);
   localparam int AW     = $clog2(PIXELS);
   localparam int CW     = AW + 1;
   localparam int DATA_W = 16;
   localparam int COEF_W = 9;
   // Factors never exceed 256, so 5-bit x factor fits 13 bits and 6-bit x factor fits 14.
   localparam int R_PW   = 13;
   localparam int G_PW   = 14;

   localparam logic [2:0] BLK_AIR        = 3'd0;
   localparam logic [2:0] BLK_WATER      = 3'd1;
   localparam logic [2:0] BLK_GRASS      = 3'd2;
   localparam logic [2:0] BLK_DIRT       = 3'd3;
   localparam logic [2:0] BLK_OAK_LOG    = 3'd4;
   localparam logic [2:0] BLK_OAK_LEAVES = 3'd5;

   function automatic logic [DATA_W-1:0] base_color(input logic [2:0] blk);
      case (blk)
         BLK_AIR:        base_color = 16'hAE5D;
         BLK_WATER:      base_color = 16'h3211;
         BLK_GRASS:      base_color = 16'h5C29;
         BLK_DIRT:       base_color = 16'h8309;
         BLK_OAK_LOG:    base_color = 16'h59C5;
         BLK_OAK_LEAVES: base_color = 16'h852E;
         default:        base_color = 16'h522A;
      endcase
   endfunction

   // Y decides first, then X, then Z; sky misses are never darkened.
   function automatic logic [COEF_W-1:0] face_factor(input logic air, input logic [5:0] n);
      logic [1:0] x, y, z;
      x = n[5:4];
      y = n[3:2];
      z = n[1:0];
      face_factor = COEF_W'(256);
      if (air)     face_factor = COEF_W'(256);
      else if (|y) face_factor = y[1] ? COEF_W'(SHADE_BOTTOM) : COEF_W'(SHADE_TOP);
      else if (|x) face_factor = COEF_W'(SHADE_X);
      else if (|z) face_factor = COEF_W'(SHADE_Z);
   endfunction

   function automatic logic [4:0] scale5(input logic [R_PW-1:0] p);
      return 5'(p >> 8);
   endfunction

   function automatic logic [5:0] scale6(input logic [G_PW-1:0] p);
      return 6'(p >> 8);
   endfunction

   function automatic logic [CW-1:0] sat_inc(input logic [CW-1:0] c);
      return (c == CW'(PIXELS)) ? c : c + 1'b1;
   endfunction

   logic              vld_p1_q, vld_p1_d;
   logic [AW-1:0]     addr_p1_q, addr_p1_d;
   logic [DATA_W-1:0] color_p1_q, color_p1_d;
   logic [5:0]        norm_p1_q, norm_p1_d;
   logic              air_p1_q, air_p1_d;

   logic              vld_p2_q, vld_p2_d;
   logic [AW-1:0]     addr_p2_q, addr_p2_d;
   logic [R_PW-1:0]   r_p2_q, r_p2_d;
   logic [G_PW-1:0]   g_p2_q, g_p2_d;
   logic [R_PW-1:0]   b_p2_q, b_p2_d;

   logic              we_q, we_d;
   logic [DATA_W-1:0] sbuf_data_q, sbuf_data_d;
   logic [AW-1:0]     sbuf_addr_q, sbuf_addr_d;
   logic [CW-1:0]     count_q, count_d;
   logic              shaded_q, shaded_d;

   logic [COEF_W-1:0] factor;
   logic [DATA_W-1:0] pixel;

   always_comb begin
      // S1: capture hit, look up base colour
      vld_p1_d   = bus.hit_valid;
      addr_p1_d  = bus.pixel_addr;
      color_p1_d = base_color(bus.hit);
      norm_p1_d  = bus.hit_norm;
      air_p1_d   = (bus.hit == BLK_AIR);

      // S2: pick face factor, multiply each channel
      factor    = face_factor(air_p1_q, norm_p1_q);
      vld_p2_d  = vld_p1_q & ~bus.frame_start;
      addr_p2_d = addr_p1_q;
      r_p2_d    = R_PW'(color_p1_q[15:11]) * R_PW'(factor);
      g_p2_d    = G_PW'(color_p1_q[10:5])  * G_PW'(factor);
      b_p2_d    = R_PW'(color_p1_q[4:0])   * R_PW'(factor);

      // S3: floor-scale, pack, write and count
      pixel       = {scale5(r_p2_q), scale6(g_p2_q), scale5(b_p2_q)};
      we_d        = vld_p2_q & ~bus.frame_start;
      sbuf_data_d = we_d ? pixel : sbuf_data_q;
      sbuf_addr_d = we_d ? addr_p2_q : sbuf_addr_q;
      count_d     = count_q;
      if (bus.frame_start) count_d = '0;
      else if (we_d)       count_d = sat_inc(count_q);
      shaded_d    = ~bus.frame_start & (shaded_q | (count_q == CW'(PIXELS)));
   end

   always_ff @(posedge clk_in or posedge rst_in) begin
      if (rst_in) begin
         vld_p1_q    <= 1'b0;
         vld_p2_q    <= 1'b0;
         we_q        <= 1'b0;
         sbuf_data_q <= '0;
         sbuf_addr_q <= '0;
         count_q     <= '0;
         shaded_q    <= 1'b0;
      end else begin
         vld_p1_q    <= vld_p1_d;
         vld_p2_q    <= vld_p2_d;
         we_q        <= we_d;
         sbuf_data_q <= sbuf_data_d;
         sbuf_addr_q <= sbuf_addr_d;
         count_q     <= count_d;
         shaded_q    <= shaded_d;
      end
   end

   // Datapath payload needs no reset; the valid bits qualify it.
   always_ff @(posedge clk_in) begin
      addr_p1_q  <= addr_p1_d;
      color_p1_q <= color_p1_d;
      norm_p1_q  <= norm_p1_d;
      air_p1_q   <= air_p1_d;
      addr_p2_q  <= addr_p2_d;
      r_p2_q     <= r_p2_d;
      g_p2_q     <= g_p2_d;
      b_p2_q     <= b_p2_d;
   end

   assign bus.sbuf_write_enable = we_q;
   assign bus.sbuf_data         = sbuf_data_q;
   assign bus.sbuf_addr         = sbuf_addr_q;
   assign bus.pixel_count       = count_q;
   assign bus.frame_shaded      = shaded_q;
endmodule
